// File: rtl/vga_frame_fetch.sv
// Vertical timing and framebuffer fetch for a 640x480 VGA stage fed by the horizontal sync generator.
// Issues sequential reads for visible pixels and keeps hsync/vsync/RGB aligned on a fixed 2-clock pipeline.
module vga_frame_fetch #(
   parameter int unsigned H_VISIBLE       = 640,
   parameter int unsigned V_TOTAL         = 525,
   parameter int unsigned V_PULSE         = 2,
   parameter int unsigned V_VISIBLE_START = 35,
   parameter int unsigned V_VISIBLE_END   = 515,
   parameter int unsigned ADDR_BIT        = 19,
   parameter int unsigned COLOR_BIT       = 8
) (
   input  logic                 clk,
   input  logic                 i_rst_n,
   input  logic                 i_sclr,
   input  logic                 i_px_clk,
   input  logic                 i_hsync_en,
   input  logic                 i_addr_en,
   input  logic [COLOR_BIT-1:0] i_rdata,
   output logic                 o_rd_en,
   output logic [ADDR_BIT-1:0]  o_raddr,
   output logic [9:0]           o_x,
   output logic [8:0]           o_y,
   output logic                 o_hsync_n,
   output logic                 o_vsync_n,
   output logic [COLOR_BIT-1:0] o_rgb,
   output logic                 o_frame_start
);

   localparam int unsigned V_W = $clog2(V_TOTAL);
   localparam int unsigned X_W = $clog2(H_VISIBLE);
   localparam int unsigned Y_W = $clog2(V_VISIBLE_END - V_VISIBLE_START);

   logic                hs_prev_q, hs_prev_d;
   logic [V_W-1:0]      v_cnt_q, v_cnt_d;
   logic [X_W-1:0]      col_q, col_d;
   logic [ADDR_BIT-1:0] addr_q, addr_d;
   logic                rd_en_q, rd_en_d;
   logic [ADDR_BIT-1:0] raddr_q, raddr_d;
   logic [X_W-1:0]      x_q, x_d;
   logic [Y_W-1:0]      y_q, y_d;
   logic                rd2_q, rd2_d;
   logic [1:0]          hs_dly_q, hs_dly_d;
   logic [1:0]          vs_dly_q, vs_dly_d;
   logic                fs_q, fs_d;

   logic line_ev, v_wrap, v_vis, px_vis, vs_c;

   // Next-state logic; synchronous clear overrides everything at the end.
   always_comb begin
      hs_prev_d = hs_prev_q;
      v_cnt_d   = v_cnt_q;
      col_d     = col_q;
      addr_d    = addr_q;
      rd_en_d   = 1'b0;
      raddr_d   = raddr_q;
      x_d       = x_q;
      y_d       = y_q;
      fs_d      = 1'b0;

      line_ev = i_px_clk & i_hsync_en & ~hs_prev_q;
      v_wrap  = line_ev && (v_cnt_q == V_W'(V_TOTAL - 1));
      v_vis   = (v_cnt_q >= V_W'(V_VISIBLE_START)) && (v_cnt_q < V_W'(V_VISIBLE_END));
      px_vis  = i_px_clk & i_addr_en & v_vis;

      if (i_px_clk) begin
         hs_prev_d = i_hsync_en;
      end

      if (line_ev) begin
         v_cnt_d = v_wrap ? '0 : v_cnt_q + V_W'(1);
         col_d   = '0;
         fs_d    = v_wrap;
         if (v_wrap) begin
            addr_d = '0;
         end
      end

      if (px_vis) begin
         rd_en_d = 1'b1;
         raddr_d = addr_q;
         x_d     = col_q;
         y_d     = Y_W'(v_cnt_q - V_W'(V_VISIBLE_START));
         col_d   = col_q + X_W'(1);
         addr_d  = addr_q + ADDR_BIT'(1);
      end

      // vsync uses the updated line count so it moves on the same edge as hsync.
      vs_c     = (v_cnt_d < V_W'(V_PULSE));
      rd2_d    = rd_en_q;
      hs_dly_d = {hs_dly_q[0], ~i_hsync_en};
      vs_dly_d = {vs_dly_q[0], ~vs_c};

      if (i_sclr) begin
         hs_prev_d = 1'b1;
         v_cnt_d   = '0;
         col_d     = '0;
         addr_d    = '0;
         rd_en_d   = 1'b0;
         raddr_d   = '0;
         x_d       = '0;
         y_d       = '0;
         fs_d      = 1'b0;
         rd2_d     = 1'b0;
         hs_dly_d  = 2'b11;
         vs_dly_d  = 2'b11;
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hs_prev_q <= 1'b1;
         v_cnt_q   <= '0;
         col_q     <= '0;
         addr_q    <= '0;
         rd_en_q   <= 1'b0;
         raddr_q   <= '0;
         x_q       <= '0;
         y_q       <= '0;
         fs_q      <= 1'b0;
         rd2_q     <= 1'b0;
         hs_dly_q  <= 2'b11;
         vs_dly_q  <= 2'b11;
      end else begin
         hs_prev_q <= hs_prev_d;
         v_cnt_q   <= v_cnt_d;
         col_q     <= col_d;
         addr_q    <= addr_d;
         rd_en_q   <= rd_en_d;
         raddr_q   <= raddr_d;
         x_q       <= x_d;
         y_q       <= y_d;
         fs_q      <= fs_d;
         rd2_q     <= rd2_d;
         hs_dly_q  <= hs_dly_d;
         vs_dly_q  <= vs_dly_d;
      end
   end

   assign o_rd_en       = rd_en_q;
   assign o_raddr       = raddr_q;
   assign o_x           = x_q;
   assign o_y           = y_q;
   assign o_frame_start = fs_q;
   assign o_hsync_n     = hs_dly_q[1];
   assign o_vsync_n     = vs_dly_q[1];
   // RAM data arrives one clock after the strobe, so colour is gated by the delayed strobe.
   assign o_rgb         = rd2_q ? i_rdata : '0;

endmodule
